asrv32_writeback: RTL

- Writeback stage of the ASRV32 core. It is the writer side of the base register file's write port: it drives the write clock-enable, destination address and data.
- Takes completed ALU results and load requests from the memory stage.
- For loads, waits on the data-memory acknowledge, then aligns and sign/zero-extends the load data.
- Stalls the upstream pipeline while a load is outstanding and flags load faults (timeout, misalignment, illegal funct3).

---
 rtl/asrv32_pkg.sv | 15 +
 rtl/asrv32_load_align.sv | 41 ++++
 rtl/asrv32_writeback.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/asrv32_pkg.sv
// Shared constants for the ASRV32 writeback stage and load aligner.
package asrv32_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM state encodings
    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_WAIT_ACK = 1'b1;

endpackage

// File: rtl/asrv32_load_align.sv
// Combinational load aligner: extracts and extends the addressed byte/half/word
// and flags misaligned or illegal loads. Shared with the LSU.
module asrv32_load_align
    import asrv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lsb,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        fault
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, then extend according to funct3
    always_comb begin
        byte_v = word[{lsb, 3'b000} +: 8];
        half_v = lsb[1] ? word[31:16] : word[15:0];
        data   = '0;
        fault  = 1'b0;
        unique case (funct3)
            F3_LB: data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'h000000, byte_v};
            F3_LH: begin
                data  = {{16{half_v[15]}}, half_v};
                fault = lsb[0];
            end
            F3_LHU: begin
                data  = {16'h0000, half_v};
                fault = lsb[0];
            end
            F3_LW: begin
                data  = word;
                fault = (lsb != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/asrv32_writeback.sv
// ASRV32 writeback stage: drives the register-file write port from ALU results
// or aligned load data, stalling upstream while a load waits for its ack.
module asrv32_writeback
    import asrv32_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMR_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_alu_data,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_mem_data,
    input  logic        i_ack,
    output logic        o_ce_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_stall,
    output logic        o_err
);

    localparam logic [TMR_W-1:0] TimerLast = TMR_W'(ACK_TIMEOUT - 1);

    logic             state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ce_wr_q, ce_wr_d;
    logic             err_q, err_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_data_q, rd_data_d;

    // Load context held while waiting for the ack
    logic       lat_wr_q, lat_wr_d;
    logic [4:0] lat_rd_q, lat_rd_d;
    logic [2:0] lat_funct3_q, lat_funct3_d;
    logic [1:0] lat_lsb_q, lat_lsb_d;

    logic [2:0]  al_funct3;
    logic [1:0]  al_lsb;
    logic [31:0] al_data;
    logic        al_fault;

    // Aligner sees the live request in IDLE and the latched one in WAIT_ACK
    always_comb begin
        al_funct3 = (state_q == ST_WAIT_ACK) ? lat_funct3_q : i_funct3;
        al_lsb    = (state_q == ST_WAIT_ACK) ? lat_lsb_q : i_addr_lsb;
    end

    asrv32_load_align u_align (
        .funct3 (al_funct3),
        .lsb    (al_lsb),
        .word   (i_mem_data),
        .data   (al_data),
        .fault  (al_fault)
    );

    // Upstream hold: outstanding load without ack, or a load issuing unacked
    always_comb begin
        o_stall = ((state_q == ST_WAIT_ACK) && !i_ack) ||
                  ((state_q == ST_IDLE) && i_ce && i_is_load && !i_ack && !i_flush);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ce_wr_d      = 1'b0;
        err_d        = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        lat_wr_d     = lat_wr_q;
        lat_rd_d     = lat_rd_q;
        lat_funct3_d = lat_funct3_q;
        lat_lsb_d    = lat_lsb_q;

        if (i_flush) begin
            // Kill anything in flight; nothing is written or reported
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (i_ce) begin
                if (!i_is_load) begin
                    ce_wr_d   = i_wr_rd && (i_rd_addr != 5'd0);
                    rd_addr_d = i_rd_addr;
                    rd_data_d = i_alu_data;
                end else if (i_ack) begin
                    if (al_fault) begin
                        err_d = 1'b1;
                    end else begin
                        ce_wr_d   = i_wr_rd && (i_rd_addr != 5'd0);
                        rd_addr_d = i_rd_addr;
                        rd_data_d = al_data;
                    end
                end else begin
                    state_d      = ST_WAIT_ACK;
                    timer_d      = '0;
                    lat_wr_d     = i_wr_rd;
                    lat_rd_d     = i_rd_addr;
                    lat_funct3_d = i_funct3;
                    lat_lsb_d    = i_addr_lsb;
                end
            end
        end else begin
            if (i_ack) begin
                // Ack beats a same-cycle timeout
                state_d = ST_IDLE;
                timer_d = '0;
                if (al_fault) begin
                    err_d = 1'b1;
                end else begin
                    ce_wr_d   = lat_wr_q && (lat_rd_q != 5'd0);
                    rd_addr_d = lat_rd_q;
                    rd_data_d = al_data;
                end
            end else if (timer_q == TimerLast) begin
                state_d = ST_IDLE;
                timer_d = '0;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            ce_wr_q      <= 1'b0;
            err_q        <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            lat_wr_q     <= 1'b0;
            lat_rd_q     <= '0;
            lat_funct3_q <= '0;
            lat_lsb_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ce_wr_q      <= ce_wr_d;
            err_q        <= err_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            lat_wr_q     <= lat_wr_d;
            lat_rd_q     <= lat_rd_d;
            lat_funct3_q <= lat_funct3_d;
            lat_lsb_q    <= lat_lsb_d;
        end
    end

    // Register-file port is driven straight from the output registers
    always_comb begin
        o_ce_wr   = ce_wr_q;
        o_err     = err_q;
        o_rd_addr = rd_addr_q;
        o_rd_data = rd_data_q;
    end

endmodule
